uart_rx_115k: RTL and testbench
===============================

# uart_rx_115k

Fixed-rate UART receiver for the 50 MHz system clock: deserialises 8N1 frames at 115200 baud (434 clocks per bit) arriving on a single serial line. Delivers each received byte on a parallel bus with a one-cycle completion strobe. Sits between the board RX pin and the CPU's memory-mapped I/O or loader logic.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per bit (50 MHz / 115200).
- FRAME_CLKS, default 10*CLKS_PER_BIT = 4340: clocks from start-bit detection to the completion strobe.
- clk_50M  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- rx  input  1  serial data; idle high.
- rx_msg  output  8  last correctly received byte; held until the next valid frame.
- rx_complete  output  1  single-cycle strobe; rx_msg is new in that same cycle.

## Operation
- Frame format: 1 start bit (0), 8 data bits, 1 stop bit (1); no parity.
- Bit order: the first data bit on the line lands in rx_msg[7], the last in rx_msg[0] (MSB-first).
  - Line bits after start 1,0,1,0,0,0,0,0 give 8'hA0.
- rx is sampled directly, with no synchroniser stage; latency below depends on this.
- State machine:
  - IDLE: counter cleared; rx sampled 0 moves to START. That edge is frame cycle 0.
  - START: at mid-bit (count CLKS_PER_BIT/2 = 217) rx must still be 0, else return to IDLE (glitch reject, no strobe). Otherwise continue to the end of the bit, then go to DATA.
  - DATA: 8 bits, each sampled at mid-bit into a shift register (shift left, new bit into LSB). 3-bit bit index; go to STOP after bit 7's full period.
  - STOP: sample rx at mid-bit.
    - On the final cycle of the stop bit (frame cycle FRAME_CLKS), if the stop sample was 1: rx_msg <= shift register, rx_complete <= 1.
    - If the stop sample was 0 (framing error): no strobe, rx_msg unchanged.
    - In both cases, return to IDLE-equivalent behaviour on that same edge: if rx is 0 at that edge, it is cycle 0 of the next frame. This supports back-to-back frames with no idle gap.
- rx held low indefinitely: repeated framing errors only. rx_complete never asserts and rx_msg keeps its last value.

## Timing
- Reset values: rx_msg = 8'h00, rx_complete = 0, state = IDLE, all counters 0.
- Reset mid-frame aborts the frame with no strobe.
- rx_complete goes high on the edge FRAME_CLKS (4340) clocks after frame cycle 0 and stays high for exactly one cycle.
- rx_msg changes only on that edge.
- Back-to-back frames produce strobes exactly 4340 cycles apart (86.8 µs).
- Counters:
  - bit-phase counter, 9 bits, wraps at CLKS_PER_BIT-1;
  - bit index, 3 bits.
  - No arithmetic overflow is possible within the defined states.

## Structure
- Shared package uart_pkg: CLKS_PER_BIT, the state enum (IDLE, START, DATA, STOP), and data width 8. The package will be reused by the transmitter.
- Single flat module; no sub-module needed. A baud tick counter is inline.

## Test plan
- Single frame, first data bits 1,0,1,0,0,0,0,0 then stop 1: rx_msg = 8'hA0 and rx_complete pulses one cycle at 4340 clocks after the start edge. rx_msg was 8'h00 before.
- Ten back-to-back frames (0x55, 0xFF, 0x00, 0x81, …) with no idle: ten strobes spaced exactly 4340 cycles; each rx_msg equals the bit-reversed line order.
- Start glitch of 100 clocks low, then high: no strobe, state returns to IDLE, rx_msg unchanged.
- Stop bit 0 (rx stuck low after a frame): no strobe; rx_msg holds the previous byte for ≥5 frame times.
- rst pulsed at data bit 4: outputs go to 0/8'h00 next edge. A subsequent clean frame 0x3C is received normally.
- rx idle high for 10000 cycles: rx_complete stays 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing at 50 MHz / 115200 baud, FSM states, data width.
// Reused by the receiver and the future transmitter.
// Contains constants and types only, no logic.
package uart_pkg;

  localparam int CLKS_PER_BIT = 434;
  localparam int DATA_W       = 8;
  localparam int CNT_W        = 9;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_115k_if.sv
// Serial line in / received byte out bundle for the UART receiver.
// The receiver takes the slave view; the line driver/consumer takes the master view.
// rx_complete is a strobe that cannot be stalled; consumers must take rx_msg that cycle.
interface uart_rx_115k_if;
  import uart_pkg::*;

  logic              rx;
  logic [DATA_W-1:0] rx_msg;
  logic              rx_complete;

  modport master (output rx, input rx_msg, input rx_complete);
  modport slave  (input rx, output rx_msg, output rx_complete);
endinterface

// File: rtl/uart_rx_115k.sv
// 8N1 UART receiver at fixed 434 clocks/bit; first line bit lands in rx_msg MSB.
// Latency: strobe FRAME_CLKS clocks after the start-bit edge (rx is not synchronised).
// Backpressure: none; rx_complete is a one-cycle strobe, rx_msg held until next good frame.
module uart_rx_115k #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int FRAME_CLKS   = 10 * CLKS_PER_BIT
) (
  input  logic          clk_50M,
  input  logic          rst,
  uart_rx_115k_if.slave bus
);
  import uart_pkg::*;

  // The bit-phase counter and the frame length are tied together; reject mismatched overrides.
  if (FRAME_CLKS != 10 * CLKS_PER_BIT) begin : g_bad_frame
    $error("FRAME_CLKS must equal 10 * CLKS_PER_BIT");
  end

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(CLKS_PER_BIT / 2);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] msg_q, msg_d;
  logic              cmpl_q, cmpl_d;

  logic bit_end;
  logic mid_bit;

  assign bit_end = (cnt_q == BIT_LAST);
  assign mid_bit = (cnt_q == BIT_MID);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      msg_q   <= '0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      msg_q   <= msg_d;
      cmpl_q  <= cmpl_d;
    end
  end

  // Next-state: end of stop bit behaves like IDLE so a low rx there starts the next frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!bus.rx) state_d = START;
      START: begin
        if (mid_bit && bus.rx) state_d = IDLE;
        else if (bit_end)      state_d = DATA;
      end
      DATA:  if (bit_end && (idx_q == IDX_W'(DATA_W - 1))) state_d = STOP;
      STOP:  if (bit_end) state_d = bus.rx ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/outputs: bit timing, mid-bit sampling, and the completion strobe.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = '0;
    shift_d = shift_q;
    stop_d  = stop_q;
    msg_d   = msg_q;
    cmpl_d  = 1'b0;

    if (state_q == IDLE || state_d == IDLE || bit_end) begin
      cnt_d = '0;
    end

    if (state_q == DATA) begin
      idx_d = bit_end ? idx_q + IDX_W'(1) : idx_q;
      if (mid_bit) begin
        shift_d = {shift_q[DATA_W-2:0], bus.rx};
      end
    end

    if (state_q == STOP) begin
      if (mid_bit) begin
        stop_d = bus.rx;
      end
      // A low stop sample is a framing error: drop the byte silently.
      if (bit_end && stop_q) begin
        msg_d  = shift_q;
        cmpl_d = 1'b1;
      end
    end
  end

  assign bus.rx_msg      = msg_q;
  assign bus.rx_complete = cmpl_q;

endmodule

// File: tb/tb_uart_rx_115k.sv
// Directed + randomized bench for uart_rx_115k with a frame-level reference model.
module tb_uart_rx_115k;
  import uart_pkg::*;

  localparam int CPB   = 434;
  localparam int FRAME = 10 * CPB;

  logic clk_50M = 1'b0;
  logic rst     = 1'b1;

  uart_rx_115k_if bus ();

  uart_rx_115k #(.CLKS_PER_BIT(CPB), .FRAME_CLKS(FRAME)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .bus     (bus)
  );

  always #10 clk_50M = ~clk_50M;

  int unsigned cyc = 0;
  logic        rst_at_edge;
  always @(posedge clk_50M) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Observed strobes and any rx_msg change that happens without a strobe.
  int unsigned strb_cyc[$];
  logic [7:0]  strb_msg[$];
  logic [7:0]  prev_msg;
  int          stray = 0;
  always @(negedge clk_50M) begin
    if (bus.rx_complete === 1'b1) begin
      strb_cyc.push_back(cyc);
      strb_msg.push_back(bus.rx_msg);
    end
    if (rst_at_edge === 1'b0 && bus.rx_msg !== prev_msg && bus.rx_complete !== 1'b1)
      stray++;
    prev_msg = bus.rx_msg;
  end

  // Reference expectations: strobe sample cycle and byte per good frame.
  int unsigned exp_cyc[$];
  logic [7:0]  exp_msg[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line bit i (i = 0 first after start) carries weight 2^(7-i).
  function automatic logic [7:0] ref_byte(input logic [7:0] line);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) v = v + int'(line[i]) * (1 << (7 - i));
    return v[7:0];
  endfunction

  // Called on a negedge; returns on the negedge where the next frame could start.
  task automatic send_frame(input logic [7:0] line, input logic stop_bit);
    bus.rx = 1'b0;
    if (stop_bit) begin
      // Strobe edge is FRAME clocks after the edge that samples this start bit.
      exp_cyc.push_back(cyc + FRAME + 1);
      exp_msg.push_back(ref_byte(line));
    end
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      bus.rx = line[i];
      repeat (CPB) @(negedge clk_50M);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk_50M);
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_count"}, strb_cyc.size(), exp_cyc.size());
    for (int j = 0; j < exp_cyc.size() && j < strb_cyc.size(); j++) begin
      check($sformatf("%s_msg%0d", tag, j), strb_msg[j], exp_msg[j]);
      check($sformatf("%s_cyc%0d", tag, j), strb_cyc[j], exp_cyc[j]);
    end
    strb_cyc.delete(); strb_msg.delete();
    exp_cyc.delete();  exp_msg.delete();
  endtask

  logic [7:0] held;
  logic [7:0] lines[10];

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk_50M);
    check("reset_msg", bus.rx_msg, 8'h00);
    check("reset_cmpl", bus.rx_complete, 1'b0);
    rst = 1'b0;

    // Idle line for 10000 cycles: no strobe.
    repeat (10000) @(negedge clk_50M);
    check_strobes("idle");

    // Single frame, line bits 1,0,1,0,0,0,0,0 -> 8'hA0, strobe exactly one cycle.
    send_frame(8'b0000_0101, 1'b1);
    check("single_pre_msg", bus.rx_msg, 8'h00);
    check("single_pre_cmpl", bus.rx_complete, 1'b0);
    @(negedge clk_50M);
    check("single_cmpl", bus.rx_complete, 1'b1);
    check("single_msg", bus.rx_msg, 8'hA0);
    @(negedge clk_50M);
    check("single_cmpl_drop", bus.rx_complete, 1'b0);
    repeat (8) @(negedge clk_50M);
    check_strobes("single");

    // Ten back-to-back frames with no idle gap.
    lines[0] = 8'h55; lines[1] = 8'hFF; lines[2] = 8'h00; lines[3] = 8'h81;
    for (int k = 4; k < 9; k++) lines[k] = 8'($urandom);
    lines[9] = 8'h96;
    for (int k = 0; k < 10; k++) send_frame(lines[k], 1'b1);
    bus.rx = 1'b1;
    repeat (10) @(negedge clk_50M);
    check_strobes("b2b");
    held = ref_byte(8'h96);

    // Start glitch of 100 clocks: rejected, nothing delivered.
    bus.rx = 1'b0;
    repeat (100) @(negedge clk_50M);
    bus.rx = 1'b1;
    repeat (600) @(negedge clk_50M);
    check_strobes("glitch");
    check("glitch_msg", bus.rx_msg, held);

    // Framing error then rx stuck low for five more frame times.
    send_frame(8'($urandom), 1'b0);
    for (int k = 0; k < 5; k++) begin
      repeat (FRAME) @(negedge clk_50M);
      check($sformatf("stuck_msg%0d", k), bus.rx_msg, held);
    end
    bus.rx = 1'b1;
    repeat (10) @(negedge clk_50M);
    check_strobes("stuck");

    // Reset in the middle of data bit 4 aborts the frame.
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    bus.rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk_50M);
    rst = 1'b1;
    @(negedge clk_50M);
    check("midrst_msg", bus.rx_msg, 8'h00);
    check("midrst_cmpl", bus.rx_complete, 1'b0);
    rst = 1'b0;
    repeat (6 * CPB) @(negedge clk_50M);
    check_strobes("midrst");

    // Clean frame after reset.
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk_50M);
    check_strobes("post_rst");
    check("final_msg", bus.rx_msg, 8'h3C);

    check("stray_msg_changes", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
